// File: rtl/game_level_fsm.sv
// Top-level game-flow controller: sequences START/PLAY/PAUSED/TRANSITION/INTERLUDE/VICTORY/DEATH,
// tracks level and remaining enemies, and drives screen selects, respawn/timer pulses and enemy speed.
module game_level_fsm #(
    parameter int NUM_LEVELS        = 2,
    parameter int ENEMIES_PER_LEVEL = 2,
    parameter int BASE_SPEED        = 120,
    parameter int SPEED_STEP        = 120,
    parameter int INTERLUDE_TICKS   = 120,
    parameter int VICTORY_TICKS     = 120
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        playerTrigger,
    input  logic        pauseToggle,
    input  logic [2:0]  currLife,
    input  logic        timeExpired,
    input  logic [2:0]  shotEnemyCollision,
    input  logic        slowClk,
    input  logic        transitionDone,
    output logic [2:0]  currentGameState,
    output logic [3:0]  level,
    output logic [2:0]  enemies_left,
    output logic [10:0] curEnemySpeed,
    output logic        pause,
    output logic        start_screen,
    output logic        transition_screen,
    output logic        death_screen,
    output logic        victory_screen,
    output logic        newLevel,
    output logic        requestTime
);

    typedef enum logic [2:0] {
        ST_START      = 3'd0,
        ST_PLAY       = 3'd1,
        ST_INTERLUDE  = 3'd2,
        ST_TRANSITION = 3'd3,
        ST_VICTORY    = 3'd4,
        ST_DEATH      = 3'd5,
        ST_PAUSED     = 3'd6
    } state_t;

    localparam logic [2:0]  EPL        = 3'(ENEMIES_PER_LEVEL);
    localparam logic [3:0]  LAST_LEVEL = 4'(NUM_LEVELS - 1);
    localparam logic [15:0] INT_TICKS  = 16'(INTERLUDE_TICKS);
    localparam logic [15:0] VIC_TICKS  = 16'(VICTORY_TICKS);

    function automatic logic [2:0] popcount3(input logic [2:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]};
    endfunction

    // Wide sum so large parameters saturate instead of wrapping.
    function automatic logic [10:0] speed_of(input logic [3:0] lvl);
        logic [31:0] s;
        s = 32'(BASE_SPEED) + 32'(lvl) * 32'(SPEED_STEP);
        if (s > 32'd2047) begin
            return 11'd2047;
        end else begin
            return s[10:0];
        end
    endfunction

    state_t      state_r, state_s;
    logic [3:0]  level_r, level_s;
    logic [2:0]  enemies_r, enemies_s;
    logic [15:0] cnt_r, cnt_s;
    logic        trig_q_r;
    logic        trig_rise_s, dead_s, pulse_s;
    logic [2:0]  kills_s;
    logic        new_level_r, request_time_r, pause_r;
    logic        start_screen_r, transition_screen_r, death_screen_r, victory_screen_r;
    logic [10:0] speed_r;

    assign trig_rise_s = playerTrigger & ~trig_q_r;
    assign dead_s      = (currLife == 3'd0) | timeExpired;
    assign kills_s     = popcount3(shotEnemyCollision);

    // Next-state, level, enemy count and tick counter.
    always_comb begin
        state_s   = state_r;
        level_s   = level_r;
        enemies_s = enemies_r;
        cnt_s     = cnt_r;
        case (state_r)
            ST_START: begin
                level_s   = 4'd0;
                enemies_s = EPL;
                if (trig_rise_s) begin
                    state_s = ST_PLAY;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_PLAY: begin
                if (kills_s >= enemies_r) begin
                    enemies_s = 3'd0;
                    if (level_r == LAST_LEVEL) begin
                        state_s = ST_VICTORY;
                        cnt_s   = VIC_TICKS;
                    end else begin
                        state_s = ST_TRANSITION;
                    end
                end else if (dead_s) begin
                    state_s   = ST_DEATH;
                    enemies_s = enemies_r - kills_s;
                end else if (pauseToggle) begin
                    state_s = ST_PAUSED;
                end else begin
                    enemies_s = enemies_r - kills_s;
                end
            end
            ST_PAUSED: begin
                if (pauseToggle) begin
                    state_s = ST_PLAY;
                end else begin
                    state_s = ST_PAUSED;
                end
            end
            ST_TRANSITION: begin
                if (transitionDone) begin
                    state_s = ST_INTERLUDE;
                    level_s = level_r + 4'd1;
                    cnt_s   = INT_TICKS;
                end else begin
                    state_s = ST_TRANSITION;
                end
            end
            ST_INTERLUDE: begin
                if (slowClk) begin
                    // A zero count is also accepted so a corrupted counter cannot stall here.
                    if (cnt_r <= 16'd1) begin
                        state_s   = ST_PLAY;
                        enemies_s = EPL;
                        cnt_s     = 16'd0;
                    end else begin
                        cnt_s = cnt_r - 16'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_VICTORY: begin
                if (trig_rise_s && (cnt_r == 16'd0)) begin
                    state_s = ST_START;
                end else if (slowClk && (cnt_r != 16'd0)) begin
                    cnt_s = cnt_r - 16'd1;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_DEATH: begin
                if (trig_rise_s) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_DEATH;
                end
            end
            default: begin
                state_s = ST_START;
            end
        endcase
        pulse_s = ((state_r == ST_START) || (state_r == ST_INTERLUDE)) && (state_s == ST_PLAY);
    end

    // State, counters and registered outputs; outputs decode the next state so they align with state_r.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r             <= ST_START;
            level_r             <= 4'd0;
            enemies_r           <= EPL;
            cnt_r               <= 16'd0;
            trig_q_r            <= 1'b0;
            new_level_r         <= 1'b0;
            request_time_r      <= 1'b0;
            pause_r             <= 1'b1;
            start_screen_r      <= 1'b1;
            transition_screen_r <= 1'b0;
            death_screen_r      <= 1'b0;
            victory_screen_r    <= 1'b0;
            speed_r             <= speed_of(4'd0);
        end else begin
            state_r             <= state_s;
            level_r             <= level_s;
            enemies_r           <= enemies_s;
            cnt_r               <= cnt_s;
            trig_q_r            <= playerTrigger;
            new_level_r         <= pulse_s;
            request_time_r      <= pulse_s;
            pause_r             <= (state_s != ST_PLAY);
            start_screen_r      <= (state_s == ST_START);
            transition_screen_r <= (state_s == ST_TRANSITION);
            death_screen_r      <= (state_s == ST_DEATH);
            victory_screen_r    <= (state_s == ST_VICTORY);
            speed_r             <= speed_of(level_s);
        end
    end

    assign currentGameState  = state_r;
    assign level             = level_r;
    assign enemies_left      = enemies_r;
    assign curEnemySpeed     = speed_r;
    assign pause             = pause_r;
    assign start_screen      = start_screen_r;
    assign transition_screen = transition_screen_r;
    assign death_screen      = death_screen_r;
    assign victory_screen    = victory_screen_r;
    assign newLevel          = new_level_r;
    assign requestTime       = request_time_r;

endmodule
